// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor_n #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         b_in,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] diff,
   output logic         b_out,
   output logic         overflow
);

   localparam int unsigned CW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
   // Only meaningful for N >= 2; guarded at its single use.
   localparam logic [CW-1:0] PEN_BIT  = (N >= 2) ? CW'(N - 2) : '0;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [N-1:0]  a_sr;
   logic [N-1:0]  b_sr;
   logic [N-1:0]  d_sr;
   logic [N-1:0]  d_shift;
   logic [CW-1:0] cnt;
   logic          brw;
   logic          brw_next;
   logic          d_bit;
   logic          msb_brw;

   // State register plus registered handshake flags that track the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         i_ready <= 1'b1;
         o_valid <= 1'b0;
      end else begin
         state   <= state_next;
         i_ready <= (state_next == S_IDLE);
         o_valid <= (state_next == S_DONE);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (i_valid) state_next = S_BUSY;
         S_BUSY:  if (cnt == LAST_BIT) state_next = S_DONE;
         S_DONE:  if (o_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Single full-subtractor cell and the result shift-in.
   always_comb begin
      d_bit            = a_sr[0] ^ b_sr[0] ^ brw;
      brw_next         = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
      d_shift          = d_sr >> 1;
      d_shift[N-1]     = d_bit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         d_sr     <= '0;
         cnt      <= '0;
         brw      <= 1'b0;
         msb_brw  <= 1'b0;
         diff     <= '0;
         b_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  brw     <= b_in;
                  msb_brw <= b_in;
                  cnt     <= '0;
               end
            end
            S_BUSY: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               d_sr <= d_shift;
               brw  <= brw_next;
               cnt  <= cnt + CW'(1);
               // Borrow entering the MSB, needed for signed overflow.
               if ((N >= 2) && (cnt == PEN_BIT)) msb_brw <= brw_next;
               if (cnt == LAST_BIT) begin
                  diff     <= d_shift;
                  b_out    <= brw_next;
                  overflow <= msb_brw ^ brw_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Directed bench for serial_subtractor_n: N=8 arithmetic, handshake, backpressure,
// mid-operation reset, and an exhaustive N=1 instance.
module tb_serial_subtractor_n;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       iv8, ir8, bin8, ov8, or8, bout8, ovf8;
   logic [7:0] a8, b8, diff8;

   logic       iv1, ir1, bin1, ov1, or1, bout1, ovf1;
   logic [0:0] a1, b1, diff1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_subtractor_n #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .i_valid(iv8), .i_ready(ir8),
      .a(a8), .b(b8), .b_in(bin8), .o_valid(ov8), .o_ready(or8),
      .diff(diff8), .b_out(bout8), .overflow(ovf8)
   );

   serial_subtractor_n #(.N(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_valid(iv1), .i_ready(ir1),
      .a(a1), .b(b1), .b_in(bin1), .o_valid(ov1), .o_ready(or1),
      .diff(diff1), .b_out(bout1), .overflow(ovf1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Handshake operands in, then wait for o_valid while checking i_ready stays low.
   task automatic op8_start(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      int cyc;
      bit ir_bad;
      a8 = av; b8 = bv; bin8 = bi; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      cyc = 0;
      ir_bad = 1'b0;
      while (!ov8 && cyc < 40) begin
         if (ir8) ir_bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      check("latency8", 32'(cyc), 32'd8);
      check("busy_ready8", 32'(ir_bad), 32'd0);
      check("done_ready8", 32'(ir8), 32'd0);
   endtask

   task automatic expect8(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
      check({tag, "_diff"}, 32'(diff8), 32'(ed));
      check({tag, "_bout"}, 32'(bout8), 32'(eb));
      check({tag, "_ovf"},  32'(ovf8),  32'(eo));
   endtask

   task automatic op8_end();
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      check("end_valid8", 32'(ov8), 32'd0);
      check("end_ready8", 32'(ir8), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d1_tab;
      logic [7:0] b1_tab;
      logic [7:0] o1_tab;
      logic [7:0] hold_d;
      logic       hold_b, hold_o;
      bit         stable, ov_seen, ready_bad;
      int         cyc;

      // Full-subtractor truth tables indexed by {a, b, b_in}.
      d1_tab = 8'b1001_0110;
      b1_tab = 8'b1000_1110;
      o1_tab = 8'b0010_0100;

      rst_n = 1'b0;
      iv8 = 0; or8 = 0; a8 = '0; b8 = '0; bin8 = 0;
      iv1 = 0; or1 = 0; a1 = '0; b1 = '0; bin1 = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      check("rst_ready8", 32'(ir8), 32'd1);
      check("rst_valid8", 32'(ov8), 32'd0);
      check("rst_diff8",  32'(diff8), 32'd0);
      check("rst_ready1", 32'(ir1), 32'd1);

      op8_start(8'h05, 8'h03, 1'b0); expect8("sub5_3", 8'h02, 1'b0, 1'b0); op8_end();
      op8_start(8'h03, 8'h05, 1'b0); expect8("sub3_5", 8'hFE, 1'b1, 1'b0); op8_end();
      op8_start(8'h00, 8'h00, 1'b1); expect8("bin_only", 8'hFF, 1'b1, 1'b0); op8_end();
      op8_start(8'h7F, 8'hFF, 1'b0); expect8("ovf_pos", 8'h80, 1'b1, 1'b1); op8_end();
      op8_start(8'hA0, 8'h20, 1'b1); expect8("bin_mid", 8'h7F, 1'b0, 1'b1); op8_end();

      // Backpressure: result must hold while inputs churn and i_valid stays high.
      op8_start(8'h80, 8'h01, 1'b0);
      expect8("ovf_neg", 8'h7F, 1'b0, 1'b1);
      hold_d = diff8; hold_b = bout8; hold_o = ovf8;
      stable = 1'b1;
      ready_bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); iv8 = 1'b1;
         @(posedge clk); #1;
         if (diff8 !== hold_d || bout8 !== hold_b || ovf8 !== hold_o || ov8 !== 1'b1) stable = 1'b0;
         if (ir8) ready_bad = 1'b1;
      end
      check("bp_stable", 32'(stable), 32'd1);
      check("bp_ready",  32'(ready_bad), 32'd0);
      iv8 = 1'b0;
      op8_end();
      check("idle_hold_diff", 32'(diff8), 32'h7F);
      @(posedge clk); #1;
      check("no_capture", 32'(ir8), 32'd1);

      // Reset asserted on the edge that would process bit 4.
      a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mid_rst_valid", 32'(ov8), 32'd0);
      check("mid_rst_ready", 32'(ir8), 32'd1);
      check("mid_rst_diff",  32'(diff8), 32'd0);
      check("mid_rst_bout",  32'(bout8), 32'd0);
      check("mid_rst_ovf",   32'(ovf8), 32'd0);
      ov_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (ov8) ov_seen = 1'b1;
      end
      check("mid_rst_no_pulse", 32'(ov_seen), 32'd0);
      op8_start(8'h55, 8'h22, 1'b0); expect8("after_rst", 8'h33, 1'b0, 1'b0); op8_end();

      // N=1: exhaustive over {a, b, b_in}.
      for (int i = 0; i < 8; i++) begin
         check("n1_ready", 32'(ir1), 32'd1);
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); bin1 = 1'(i); iv1 = 1'b1;
         @(posedge clk); #1;
         iv1 = 1'b0;
         cyc = 0;
         while (!ov1 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("n1_latency", 32'(cyc), 32'd1);
         check("n1_diff", 32'(diff1), 32'(d1_tab[i]));
         check("n1_bout", 32'(bout1), 32'(b1_tab[i]));
         check("n1_ovf",  32'(ovf1),  32'(o1_tab[i]));
         or1 = 1'b1;
         @(posedge clk); #1;
         or1 = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_n.md
Name: serial_subtractor_n

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - b_in, one bit per clock, LSB first.
- It is the subtract-direction counterpart to the team's combinational ripple-carry adder. It trades latency for a single full-subtractor cell plus shift registers.
- Valid/ready handshake on both the operand side and the result side, so it drops into streaming datapaths.

Parameters:
N, 8, operand/result width in bits (N >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
i_valid  input  1  operand bundle valid
i_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  minuend, unsigned or two's complement
b  input  N  subtrahend
b_in  input  1  borrow-in
o_valid  output  1  result valid
o_ready  input  1  downstream accepts result
diff  output  N  a - b - b_in, modulo 2^N
b_out  output  1  borrow out of MSB (1 = unsigned underflow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Decided: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n low at a rising edge):
  - state=IDLE, bit counter=0, borrow register=0.
  - Shift registers cleared; diff=0, b_out=0, overflow=0, o_valid=0.
  - i_ready reflects state (1 after reset). No transfer is accepted on an edge where rst_n is low.
  - Reset mid-operation abandons the operation with no result.
- States: IDLE, BUSY, DONE.
- IDLE:
  - i_ready=1, o_valid=0.
  - On an edge with i_valid=1: capture a into A_sr, b into B_sr, b_in into the borrow register; counter=0; go to BUSY.
- BUSY:
  - i_ready=0, o_valid=0. Inputs a, b, b_in and i_valid are ignored.
  - Each edge computes d = A_sr[0] ^ B_sr[0] ^ brw and brw_next = (~A_sr[0] & B_sr[0]) | (~(A_sr[0] ^ B_sr[0]) & brw).
  - A_sr and B_sr shift right. d shifts into D_sr at the MSB. brw takes brw_next; counter increments.
  - On the edge processing bit N-2 (only when N>=2), latch brw_next as msb_borrow_in. For N=1, msb_borrow_in is the captured b_in.
  - On the edge processing bit N-1 (counter == N-1), go to DONE.
- DONE:
  - o_valid=1, i_ready=0.
  - diff=D_sr; b_out=brw; overflow = msb_borrow_in ^ brw.
  - All outputs are held stable until an edge with o_ready=1, then go to IDLE.
- Latency and throughput:
  - Operand handshake at edge t0 -> o_valid high from edge t0+N.
  - Minimum initiation interval is N+2 cycles (no overlap: i_ready is 0 in DONE even if o_ready=1).
- Outputs are registered.
  - diff, b_out and overflow are meaningful only while o_valid=1.
  - They hold their last values in IDLE and clear only on reset.
- Arithmetic: result is modulo 2^N; b_out=1 iff a < b + b_in (unsigned).
- Counter width is $clog2(N)+1. Wrap-around never occurs because the counter is reset on load.

Test Plan:
- N=8, a=0x05, b=0x03, b_in=0 -> after 8 cycles o_valid=1, diff=0x02, b_out=0, overflow=0; i_ready low for cycles t0+1..t0+9.
- a=0x03, b=0x05, b_in=0 -> diff=0xFE, b_out=1, overflow=0. Separately, a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1, overflow=0.
- Signed overflow:
  - a=0x80, b=0x01 -> diff=0x7F, b_out=0, overflow=1.
  - a=0x7F, b=0xFF -> diff=0x80, b_out=1, overflow=1.
- Backpressure:
  - Hold o_ready=0 for 5 cycles in DONE, toggling a/b and holding i_valid=1.
  - Required: diff, b_out and overflow stable, i_ready=0, no new capture.
  - After o_ready=1 for one edge: IDLE and i_ready=1.
- Reset mid-op:
  - Assert rst_n=0 for one edge at bit 4 of a=0x55, b=0x22.
  - Required: next cycle state IDLE, o_valid=0, outputs 0, i_ready=1; no o_valid pulse.
  - A subsequent 0x55-0x22 yields diff=0x33.
- N=1 instance: exhaustive a, b, b_in (8 cases) -> diff and b_out match a 1-bit full subtractor; overflow = b_in ^ b_out; o_valid 1 cycle after accept.
